cc_unit: RTL

CC_UNIT -- requirements
Module: cc_unit

---
 rtl/cc_pkg.sv | 22 ++
 rtl/cc_stack.sv | 54 +++++
 rtl/cc_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared types and helpers for the condition-code unit: the {n,z,p} struct,
// its reset value, and derivation of a CC from a classified result.
package cc_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_RESET = 3'b111;

  // The caller supplies the sign bit and zero test, so one helper serves any data width.
  function automatic cc_t derive_cc(input logic sign_bit, input logic is_zero);
    cc_t cc;
    cc.n = sign_bit;
    cc.z = is_zero;
    cc.p = !sign_bit && !is_zero;
    return cc;
  endfunction

endpackage

// File: rtl/cc_stack.sv
// LIFO of condition codes with DEPTH entries. It accepts push and pop only
// when they are legal: push needs a free entry and pop needs an occupied one.
module cc_stack
  import cc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cc_t  push_data,
  output cc_t  top,
  output logic full,
  output logic empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] top_idx;
  cc_t           mem_q [DEPTH];

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_idx = cnt_q - CW'(1);
  assign top     = mem_q[top_idx[PW-1:0]];

  always_comb begin
    cnt_d = cnt_q;
    if (push && !full) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is not reset; after reset the count alone marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[cnt_q[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/cc_unit.sv
// Condition-code register with branch evaluation. Define CC_STACK_EN to add
// the CC save stack (push/pop, full/empty, sticky err); without it they are inert.
module cc_unit
  import cc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load_direct,
  input  logic [2:0]            cc_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic [2:0]            br_nzp,
  output logic [2:0]            cc_out,
  output logic                  branch_enable,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);

  cc_t  cc_q, cc_d;
  cc_t  derived_cc;
  cc_t  pop_cc;
  logic pop_ok;

  assign derived_cc = derive_cc(data_in[DATA_WIDTH-1], data_in == '0);

`ifdef CC_STACK_EN
  logic push_ok;
  logic err_q, err_d;
  logic stk_full, stk_empty;

  // Simultaneous push and pop is treated as misuse and neither is performed.
  assign push_ok = push && !pop && !stk_full;
  assign pop_ok  = pop && !push && !stk_empty;

  cc_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_ok),
    .pop      (pop_ok),
    .push_data(cc_q),
    .top      (pop_cc),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  always_comb begin
    err_d = err_q;
    if ((push && pop) || (push && stk_full) || (pop && stk_empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign full  = stk_full;
  assign empty = stk_empty;
  assign err   = err_q;
`else
  logic unused_stack_ctl;

  assign unused_stack_ctl = push ^ pop;
  assign pop_ok           = 1'b0;
  assign pop_cc           = CC_RESET;
  assign full             = 1'b0;
  assign empty            = 1'b1;
  assign err              = 1'b0;
`endif

  always_comb begin
    cc_d = cc_q;
    if (pop_ok) begin
      cc_d = pop_cc;
    end else if (load_direct) begin
      cc_d = cc_t'(cc_in);
    end else if (load) begin
      cc_d = derived_cc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cc_out        = cc_q;
  assign branch_enable = |(br_nzp & cc_q);

endmodule
